// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C requester arbiter: state encoding,
// bus-free gap derivation and the idle/timeout read value.
package i2c_arb_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      GAP       = 3'd4
   } arb_state_t;

   localparam int unsigned F_CLK_HZ  = 50_000_000;
   localparam int unsigned F_VEL_HZ  = 1_250_000;
   // One SCL bit period of bus-free time between transactions.
   localparam int unsigned T_BUF_DEF = F_CLK_HZ / F_VEL_HZ;

   localparam logic [7:0] RX_IDLE = 8'hFF;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin selector: first set req bit at or above ptr,
// wrapping at N_REQ.
module i2c_rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [ID_W-1:0]  winner,
   output logic             valid
);

   logic [2*N_REQ-1:0] rot;
   int unsigned        sum;

   always_comb begin
      rot    = {req, req} >> ptr;
      sum    = 0;
      winner = '0;
      valid  = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (!valid && rot[i]) begin
            valid  = 1'b1;
            sum    = 32'(ptr) + i;
            winner = ID_W'((sum >= N_REQ) ? sum - N_REQ : sum);
         end
      end
   end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master engine between N_REQ requesters.
// Optional watchdog on the master handshake: define I2C_ARB_TIMEOUT_EN.
module i2c_req_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned ID_W        = 2,
   parameter int unsigned T_BUF       = T_BUF_DEF,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_adr_com,
   input  logic [8*N_REQ-1:0] req_adr_reg,
   input  logic [8*N_REQ-1:0] req_dat_reg,
   output logic [N_REQ-1:0]   ack,
   output logic [7:0]         rsp_rx_dat,
   output logic               rsp_err,
   output logic               busy,
   output logic [ID_W-1:0]    grant_id,
   output logic               m_st,
   output logic [7:0]         m_adr_com,
   output logic [7:0]         m_adr_reg,
   output logic [7:0]         m_dat_reg,
   input  logic               m_en_tx,
   input  logic               m_err_ac,
   input  logic [7:0]         m_rx_dat
);

   localparam int unsigned GAP_W = (T_BUF < 1) ? 1 : $clog2(T_BUF + 1);

   arb_state_t       state;
   logic [ID_W-1:0]  ptr;
   logic [GAP_W-1:0] gap_cnt;
   logic [ID_W-1:0]  pick_id;
   logic             pick_vld;
   logic [ID_W-1:0]  nxt_ptr;

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] t_cnt;
`endif

   i2c_rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req    (req),
      .ptr    (ptr),
      .winner (pick_id),
      .valid  (pick_vld)
   );

   assign nxt_ptr = (pick_id == ID_W'(N_REQ - 1)) ? '0 : pick_id + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ptr        <= '0;
         gap_cnt    <= '0;
         ack        <= '0;
         rsp_rx_dat <= '0;
         rsp_err    <= 1'b0;
         busy       <= 1'b0;
         grant_id   <= '0;
         m_st       <= 1'b0;
         m_adr_com  <= '0;
         m_adr_reg  <= '0;
         m_dat_reg  <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
         t_cnt      <= '0;
`endif
      end else begin
         ack  <= '0;
         m_st <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_vld && !m_en_tx) begin
                  m_adr_com <= req_adr_com[8*pick_id +: 8];
                  m_adr_reg <= req_adr_reg[8*pick_id +: 8];
                  m_dat_reg <= req_dat_reg[8*pick_id +: 8];
                  grant_id  <= pick_id;
                  ptr       <= nxt_ptr;
                  m_st      <= 1'b1;
                  busy      <= 1'b1;
                  state     <= START;
               end
            end
            START: begin
`ifdef I2C_ARB_TIMEOUT_EN
               t_cnt <= '0;
`endif
               state <= WAIT_BUSY;
            end
            WAIT_BUSY, WAIT_DONE: begin
`ifdef I2C_ARB_TIMEOUT_EN
               // Watchdog wins over the normal handshake in its final cycle.
               t_cnt <= t_cnt + 1'b1;
               if (t_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                  rsp_rx_dat <= RX_IDLE;
                  rsp_err    <= 1'b1;
                  ack        <= N_REQ'(1) << grant_id;
                  gap_cnt    <= GAP_W'(T_BUF);
                  state      <= GAP;
               end else
`endif
               if (state == WAIT_BUSY) begin
                  if (m_en_tx)
                     state <= WAIT_DONE;
               end else if (!m_en_tx) begin
                  rsp_rx_dat <= m_rx_dat;
                  rsp_err    <= m_err_ac;
                  ack        <= N_REQ'(1) << grant_id;
                  gap_cnt    <= GAP_W'(T_BUF);
                  state      <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt <= GAP_W'(1)) begin
                  gap_cnt <= '0;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter with a behavioural I2C master
// and a round-robin reference model; timeout test under I2C_ARB_TIMEOUT_EN.
module tb_i2c_req_arbiter;

   localparam int N    = 4;
   localparam int TBUF = 40;
`ifdef I2C_ARB_TIMEOUT_EN
   localparam int TO      = 64;
   localparam int EN_HOLD = 40;
`else
   localparam int TO      = 4096;
   localparam int EN_HOLD = 100;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [8*N-1:0] req_adr_com, req_adr_reg, req_dat_reg;
   logic [N-1:0]   ack;
   logic [7:0]     rsp_rx_dat;
   logic           rsp_err, busy;
   logic [1:0]     grant_id;
   logic           m_st;
   logic [7:0]     m_adr_com, m_adr_reg, m_dat_reg;
   logic           m_en_tx, m_err_ac;
   logic [7:0]     m_rx_dat;

   logic           en_model, en_force, master_dead;
   logic [7:0]     mdl_rx;
   logic           mdl_err;
   logic [7:0]     b_com[N], b_reg[N], b_dat[N];

   int tests = 0;
   int fails = 0;
   int mdl_ptr = 0;

   assign m_en_tx  = en_model | en_force;
   assign m_rx_dat = mdl_rx;
   assign m_err_ac = mdl_err;

   always #5 clk = ~clk;

   i2c_req_arbiter #(
      .N_REQ       (N),
      .ID_W        (2),
      .T_BUF       (TBUF),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .req_adr_com (req_adr_com),
      .req_adr_reg (req_adr_reg),
      .req_dat_reg (req_dat_reg),
      .ack         (ack),
      .rsp_rx_dat  (rsp_rx_dat),
      .rsp_err     (rsp_err),
      .busy        (busy),
      .grant_id    (grant_id),
      .m_st        (m_st),
      .m_adr_com   (m_adr_com),
      .m_adr_reg   (m_adr_reg),
      .m_dat_reg   (m_dat_reg),
      .m_en_tx     (m_en_tx),
      .m_err_ac    (m_err_ac),
      .m_rx_dat    (m_rx_dat)
   );

   // Behavioural master: en_tx rises 3 cycles after start, held EN_HOLD cycles.
   initial begin
      en_model = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (m_st === 1'b1 && !master_dead) begin
            repeat (3) @(posedge clk);
            #1 en_model = 1'b1;
            repeat (EN_HOLD) @(posedge clk);
            #1 en_model = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   function automatic int rr_expect(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++)
         if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_bytes(input int i, input logic [7:0] c, input logic [7:0] r, input logic [7:0] d);
      b_com[i] = c;
      b_reg[i] = r;
      b_dat[i] = d;
      req_adr_com[8*i +: 8] = c;
      req_adr_reg[8*i +: 8] = r;
      req_dat_reg[8*i +: 8] = d;
   endtask

   task automatic wait_mst(output int cyc);
      cyc = 0;
      while (m_st !== 1'b1 && cyc < 1000) begin
         tick();
         cyc++;
      end
   endtask

   task automatic wait_ack(output int cyc, output bit st_seen);
      cyc = 0;
      st_seen = 0;
      while (ack === '0 && cyc < 2000) begin
         tick();
         cyc++;
         if (m_st === 1'b1) st_seen = 1;
      end
   endtask

   task automatic wait_idle;
      int c;
      c = 0;
      while (busy === 1'b1 && c < 500) begin
         tick();
         c++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      req = '0;
      en_force = 1'b0;
      master_dead = 1'b0;
      mdl_rx = 8'h00;
      mdl_err = 1'b0;
      for (int i = 0; i < N; i++) set_bytes(i, 8'h00, 8'h00, 8'h00);
      repeat (3) tick();
      tests++;
      if ({ack, rsp_rx_dat, rsp_err, busy, grant_id, m_st, m_adr_com, m_adr_reg, m_dat_reg} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got %h, required 0",
                  {ack, rsp_rx_dat, rsp_err, busy, grant_id, m_st, m_adr_com, m_adr_reg, m_dat_reg});
      end
      rst_n = 1'b1;
      tick();
      tests++;
      if (busy !== 1'b0 || m_st !== 1'b0) begin
         fails++;
         $display("FAIL reset_release_idle: busy=%b m_st=%b, required 0 0", busy, m_st);
      end
      mdl_ptr = 0;
   endtask

   task automatic test_single;
      int c, cnt, exp;
      bit st, extra;
      logic [7:0] d;
      d = 8'($urandom);
      set_bytes(1, 8'hA1, 8'h10, d);
      mdl_rx = 8'h5A;
      mdl_err = 1'b0;
      req = 4'b0010;
      exp = rr_expect(req, mdl_ptr);
      tick();
      tests++;
      if (m_st !== 1'b1) begin
         fails++;
         $display("FAIL single_start_latency: m_st=%b, required 1", m_st);
      end
      tests++;
      if (grant_id !== 2'(exp)) begin
         fails++;
         $display("FAIL single_grant_id: got %0d, required %0d", grant_id, exp);
      end
      tests++;
      if ({m_adr_com, m_adr_reg, m_dat_reg} !== {8'hA1, 8'h10, d}) begin
         fails++;
         $display("FAIL single_bytes: got %h %h %h, required a1 10 %h", m_adr_com, m_adr_reg, m_dat_reg, d);
      end
      tick();
      tests++;
      if (m_st !== 1'b0) begin
         fails++;
         $display("FAIL single_start_width: m_st=%b, required 0", m_st);
      end
      wait_ack(c, st);
      tests++;
      if (ack !== 4'b0010 || rsp_rx_dat !== 8'h5A || rsp_err !== 1'b0 || st) begin
         fails++;
         $display("FAIL single_ack: ack=%b rx=%h err=%b restart=%0d, required 0010 5a 0 0", ack, rsp_rx_dat, rsp_err, st);
      end
      req = '0;
      cnt = 0;
      extra = 0;
      while (busy === 1'b1 && cnt < 200) begin
         if (cnt > 0 && ack !== '0) extra = 1;
         tick();
         cnt++;
      end
      tests++;
      if (cnt != TBUF || extra) begin
         fails++;
         $display("FAIL single_gap: busy cycles from ack=%0d extra_ack=%0d, required %0d 0", cnt, extra, TBUF);
      end
      tests++;
      if (m_adr_com !== 8'hA1 || rsp_rx_dat !== 8'h5A) begin
         fails++;
         $display("FAIL single_hold: m_adr_com=%h rx=%h, required a1 5a", m_adr_com, rsp_rx_dat);
      end
      mdl_ptr = (exp + 1) % N;
   endtask

   task automatic test_contention;
      int c, exp;
      bit st;
      for (int i = 0; i < N; i++) set_bytes(i, 8'($urandom), 8'($urandom), 8'($urandom));
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_mst(c);
         exp = rr_expect(req, mdl_ptr);
         tests++;
         if (m_st !== 1'b1) begin
            fails++;
            $display("FAIL contention_start_%0d: no start within bound, required start", k);
         end
         if (k > 0) begin
            tests++;
            if (c != TBUF + 1) begin
               fails++;
               $display("FAIL contention_gap_%0d: cycles ack->start=%0d, required %0d", k, c, TBUF + 1);
            end
         end
         tests++;
         if (grant_id !== 2'(exp) || {m_adr_com, m_adr_reg, m_dat_reg} !== {b_com[exp], b_reg[exp], b_dat[exp]}) begin
            fails++;
            $display("FAIL contention_grant_%0d: id=%0d bytes=%h%h%h, required %0d %h%h%h", k, grant_id,
                     m_adr_com, m_adr_reg, m_dat_reg, exp, b_com[exp], b_reg[exp], b_dat[exp]);
         end
         mdl_rx = 8'($urandom);
         mdl_err = 1'($urandom);
         wait_ack(c, st);
         tests++;
         if (ack !== 4'(1 << exp) || rsp_rx_dat !== mdl_rx || rsp_err !== mdl_err || st) begin
            fails++;
            $display("FAIL contention_ack_%0d: ack=%b rx=%h err=%b restart=%0d, required %b %h %b 0", k, ack,
                     rsp_rx_dat, rsp_err, st, 4'(1 << exp), mdl_rx, mdl_err);
         end
         mdl_ptr = (exp + 1) % N;
         if (k == 4) req = '0;
      end
      wait_idle();
   endtask

   task automatic test_wrap;
      int c, exp;
      bit st;
      req = 4'b1001;
      for (int k = 0; k < 2; k++) begin
         wait_mst(c);
         exp = rr_expect(req, mdl_ptr);
         tests++;
         if (m_st !== 1'b1 || grant_id !== 2'(exp)) begin
            fails++;
            $display("FAIL wrap_grant_%0d: m_st=%b id=%0d, required 1 %0d", k, m_st, grant_id, exp);
         end
         mdl_rx = 8'($urandom);
         mdl_err = 1'b0;
         wait_ack(c, st);
         tests++;
         if (ack !== 4'(1 << exp) || rsp_rx_dat !== mdl_rx) begin
            fails++;
            $display("FAIL wrap_ack_%0d: ack=%b rx=%h, required %b %h", k, ack, rsp_rx_dat, 4'(1 << exp), mdl_rx);
         end
         req[exp] = 1'b0;
         mdl_ptr = (exp + 1) % N;
      end
      wait_idle();
   endtask

   task automatic test_random;
      int c, exp;
      bit st;
      logic [N-1:0] pending, add;
      pending = '0;
      for (int t = 0; t < 10; t++) begin
         if (pending == '0) begin
            pending = N'($urandom_range(1, 15));
            for (int i = 0; i < N; i++)
               if (pending[i]) set_bytes(i, 8'($urandom), 8'($urandom), 8'($urandom));
            req = pending;
         end
         wait_mst(c);
         exp = rr_expect(pending, mdl_ptr);
         tests++;
         if (m_st !== 1'b1 || grant_id !== 2'(exp) ||
             {m_adr_com, m_adr_reg, m_dat_reg} !== {b_com[exp], b_reg[exp], b_dat[exp]}) begin
            fails++;
            $display("FAIL random_grant_%0d: m_st=%b id=%0d bytes=%h%h%h, required 1 %0d %h%h%h", t, m_st, grant_id,
                     m_adr_com, m_adr_reg, m_dat_reg, exp, b_com[exp], b_reg[exp], b_dat[exp]);
         end
         mdl_rx = 8'($urandom);
         mdl_err = 1'($urandom);
         wait_ack(c, st);
         tests++;
         if (ack !== 4'(1 << exp) || rsp_rx_dat !== mdl_rx || rsp_err !== mdl_err || st) begin
            fails++;
            $display("FAIL random_ack_%0d: ack=%b rx=%h err=%b restart=%0d, required %b %h %b 0", t, ack,
                     rsp_rx_dat, rsp_err, st, 4'(1 << exp), mdl_rx, mdl_err);
         end
         pending[exp] = 1'b0;
         add = N'($urandom_range(0, 15)) & ~pending;
         add[exp] = 1'b0;
         for (int i = 0; i < N; i++)
            if (add[i]) set_bytes(i, 8'($urandom), 8'($urandom), 8'($urandom));
         pending = pending | add;
         req = pending;
         mdl_ptr = (exp + 1) % N;
      end
      req = '0;
      wait_idle();
      wait_idle();
   endtask

   task automatic test_ack_error;
      int c, exp;
      bit st;
      set_bytes(2, 8'h51, 8'h22, 8'h33);
      mdl_err = 1'b1;
      mdl_rx = 8'($urandom);
      req = 4'b0100;
      exp = rr_expect(req, mdl_ptr);
      wait_mst(c);
      wait_ack(c, st);
      tests++;
      if (ack !== 4'(1 << exp) || rsp_err !== 1'b1 || rsp_rx_dat !== mdl_rx) begin
         fails++;
         $display("FAIL ack_error: ack=%b err=%b rx=%h, required %b 1 %h", ack, rsp_err, rsp_rx_dat, 4'(1 << exp), mdl_rx);
      end
      req = '0;
      mdl_err = 1'b0;
      mdl_ptr = (exp + 1) % N;
      wait_idle();
   endtask

   task automatic test_reset_mid;
      int c, exp;
      bit st, early;
      set_bytes(0, 8'hC4, 8'h01, 8'h99);
      req = 4'b0001;
      wait_mst(c);
      c = 0;
      while (en_model !== 1'b1 && c < 20) begin
         tick();
         c++;
      end
      repeat (5) tick();
      en_force = 1'b1;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({ack, rsp_rx_dat, rsp_err, busy, grant_id, m_st, m_adr_com, m_adr_reg, m_dat_reg} !== '0) begin
         fails++;
         $display("FAIL midreset_outputs: got %h, required 0",
                  {ack, rsp_rx_dat, rsp_err, busy, grant_id, m_st, m_adr_com, m_adr_reg, m_dat_reg});
      end
      repeat (3) tick();
      rst_n = 1'b1;
      mdl_ptr = 0;
      early = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (m_st === 1'b1 || busy === 1'b1 || ack !== '0) early = 1;
      end
      tests++;
      if (early) begin
         fails++;
         $display("FAIL midreset_hold_off: activity while en_tx high=%0d, required 0", early);
      end
      en_force = 1'b0;
      exp = rr_expect(req, mdl_ptr);
      wait_mst(c);
      tests++;
      if (m_st !== 1'b1 || grant_id !== 2'(exp) || m_en_tx !== 1'b0) begin
         fails++;
         $display("FAIL midreset_regrant: m_st=%b id=%0d en_tx=%b, required 1 %0d 0", m_st, grant_id, m_en_tx, exp);
      end
      mdl_rx = 8'($urandom);
      wait_ack(c, st);
      tests++;
      if (ack !== 4'(1 << exp) || rsp_rx_dat !== mdl_rx) begin
         fails++;
         $display("FAIL midreset_ack: ack=%b rx=%h, required %b %h", ack, rsp_rx_dat, 4'(1 << exp), mdl_rx);
      end
      req = '0;
      mdl_ptr = (exp + 1) % N;
      wait_idle();
   endtask

`ifdef I2C_ARB_TIMEOUT_EN
   task automatic test_timeout;
      int c, exp;
      bit st;
      master_dead = 1'b1;
      set_bytes(2, 8'h77, 8'h88, 8'h99);
      mdl_rx = 8'h12;
      req = 4'b0100;
      exp = rr_expect(req, mdl_ptr);
      wait_mst(c);
      wait_ack(c, st);
      tests++;
      if (c != TO + 1 || ack !== 4'(1 << exp) || rsp_err !== 1'b1 || rsp_rx_dat !== 8'hFF) begin
         fails++;
         $display("FAIL timeout: start->ack=%0d ack=%b err=%b rx=%h, required %0d %b 1 ff", c, ack, rsp_err,
                  rsp_rx_dat, TO + 1, 4'(1 << exp));
      end
      req = '0;
      master_dead = 1'b0;
      mdl_ptr = (exp + 1) % N;
      wait_idle();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_wrap();
      test_random();
      test_ack_error();
      test_reset_mid();
`ifdef I2C_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
Round-robin scheduler that shares one I2C master engine between N_REQ on-chip requesters. It latches the winning requester's transaction bytes (address-command, register address, data) and holds them stable on the master inputs. It issues a one-cycle start pulse, tracks the master's en_tx activity to detect completion, and returns read data and an ACK-error flag to the winner. It then enforces a bus-free gap before the next grant.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, grant index width (clog2(N_REQ), min 1)
T_BUF, 40, bus-free cycles between transactions (one SCL bit period at Fclk=50 MHz, Fvel=1.25 MHz)
TIMEOUT_CYC, 4096, watchdog limit in clk cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester request level
req_adr_com  in  8*N_REQ  per-requester address-command; [7:1] slave address, [0] R/W
req_adr_reg  in  8*N_REQ  per-requester register address
req_dat_reg  in  8*N_REQ  per-requester write data
ack  out  N_REQ  one-cycle completion pulse to the granted requester
rsp_rx_dat  out  8  read data, valid while ack is high
rsp_err  out  1  ACK error or timeout, valid while ack is high
busy  out  1  high in any state other than IDLE
grant_id  out  ID_W  index of the current or last winner
m_st  out  1  start pulse to the master
m_adr_com  out  8  held ADR_COM to the master
m_adr_reg  out  8  held adr_REG to the master
m_dat_reg  out  8  held dat_REG to the master
m_en_tx  in  1  master transfer-active flag
m_err_ac  in  1  master ACK-error flag
m_rx_dat  in  8  master RX_dat

Behaviour:
- Reset values: all outputs 0. state=IDLE. Round-robin pointer=0. Gap and timeout counters=0.
- Reset mid-transaction: everything clears immediately and m_st drops. No ack is issued for the aborted transaction. The controller does not grant again until m_en_tx==0.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - Grants when |req and m_en_tx==0.
  - Winner is the first set req bit searching upward from pointer, wrapping at N_REQ.
  - On the grant edge: latch that requester's three bytes into m_adr_com/m_adr_reg/m_dat_reg, set grant_id, set pointer=(winner+1) mod N_REQ, go to START.
- START: m_st=1 for exactly this one cycle, then go to WAIT_BUSY. Latency from req sampled high in IDLE to m_st high is 1 cycle.
- WAIT_BUSY: stay until m_en_tx==1, then go to WAIT_DONE.
- WAIT_DONE:
  - Stay while m_en_tx==1.
  - On the first cycle with m_en_tx==0: register rsp_rx_dat<=m_rx_dat, rsp_err<=m_err_ac, ack[grant_id]<=1 for one cycle, load gap counter=T_BUF, go to GAP.
- GAP:
  - Decrement the gap counter; go to IDLE when it reaches 0.
  - GAP lasts max(T_BUF,1) cycles.
  - req changes are ignored during GAP.
- m_adr_com/m_adr_reg/m_dat_reg hold their values from the grant until the next grant. rsp_rx_dat/rsp_err hold until the next ack.
- Requester contract:
  - Hold req and its bytes stable until its ack.
  - The requester must drop req in the ack cycle or the next cycle; otherwise it re-enters arbitration.
  - A req that deasserts before grant is simply not selected.
- Simultaneous requests: round-robin guarantees each active requester is served within N_REQ transactions.
- Only one transaction is outstanding at a time. ack is one-hot or zero.

Optional Feature:
I2C_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT_BUSY and counts in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT_CYC, force the ack path: ack[grant_id]=1, rsp_err=1, rsp_rx_dat=8'hFF, then go to GAP.
  - This covers both a master that never starts and one that never finishes.
- Undefined: no counter. The controller waits indefinitely in WAIT_BUSY and WAIT_DONE.

Decomposition:
- Shared include/package i2c_arb_pkg holds:
  - the state encoding localparams (IDLE=0..GAP=4);
  - the default T_BUF derivation from Fclk/Fvel;
  - the 8'hFF idle/timeout read value.
- One sub-module, i2c_rr_pick: combinational round-robin selector with inputs req and pointer, outputs winner index and a valid flag. It is instantiated once and tested standalone.

Test Plan:
- Bench: a behavioural master model raises en_tx 3 cycles after m_st, holds it for 100 cycles, and reports m_rx_dat=8'h5A, m_err_ac=0.
- Single request: req=4'b0010 with adr_com=8'hA1, adr_reg=8'h10 -> m_st pulses one cycle after req; m_adr_com=8'hA1, m_adr_reg=8'h10; ack=4'b0010 with rsp_rx_dat=8'h5A, rsp_err=0; busy stays high T_BUF=40 cycles after ack.
- Contention: req=4'b1111 held -> grant order 0,1,2,3,0; each ack one-hot; no m_st during GAP.
- Wrap: pointer=3 after serving requester 2, then req=4'b1001 -> requester 3 is granted first, then 0.
- ACK error: model reports m_err_ac=1 at completion -> ack pulses with rsp_err=1.
- Async reset with rst_n low in WAIT_DONE -> all outputs 0 immediately, no ack; with m_en_tx still 1 after release, no grant until m_en_tx==0.
- With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYC=64, model never raises en_tx -> ack at cycle 64 after WAIT_BUSY entry, rsp_err=1, rsp_rx_dat=8'hFF.
